// File: rtl/event_counter_bank.sv
// Bank of independent event counters, gated by a start/run/done sequence.
// Channel 0 reaching LIMIT ends the run; each channel has hit/sticky/ovf flags.
module event_counter_bank #(
    parameter int              NUM_CH   = 4,
    parameter int              CNT_W    = 32,
    parameter bit              SATURATE = 1'b0,
    parameter longint unsigned LIMIT    = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       inc,
    input  logic [NUM_CH*CNT_W-1:0] cmp_val,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       hit,
    output logic [NUM_CH-1:0]       hit_sticky,
    output logic [NUM_CH-1:0]       ovf,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIM     = CNT_W'(LIMIT);

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] step;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] hit_d;
    logic              counting;

    assign counting = (state_q == RUN);

    // step marks a real change of value; a saturated hold never hits
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            step[i]  = 1'b0;
            wrap[i]  = 1'b0;
            hit_d[i] = 1'b0;
            if (counting && inc[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    wrap[i] = 1'b1;
                    if (!SATURATE) begin
                        cnt_d[i] = '0;
                        step[i]  = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    step[i]  = 1'b1;
                end
                hit_d[i] = step[i] &&
                           (cnt_d[i] == cmp_val[i*CNT_W +: CNT_W]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (step[0] && cnt_d[0] == LIM) state_d = DONE;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hit        <= '0;
            hit_sticky <= '0;
            ovf        <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else if (clear) begin
            state_q    <= IDLE;
            hit        <= '0;
            hit_sticky <= '0;
            ovf        <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            hit        <= hit_d;
            hit_sticky <= hit_sticky | hit_d;
            ovf        <= ovf | wrap;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
